imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Byte-stream program loader: the write side of the core's instruction memory, which the core only reads.
- Receives a length-prefixed little-endian image over a valid/ready byte interface and assembles 32-bit words.
- Issues one write per word into instruction memory.
- Holds the core in reset until the image is complete.
- Sits between a host byte source (UART RX / test bench) and the instruction memory write port, beside the core top.

Parameters:
DEPTH_WORDS, 256, instruction memory capacity in 32-bit words
ADDR_W, 10, width of byte address driven to instruction memory

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-low (sampled on clk rising edge)
start  input  1  single-cycle pulse; begins a load from IDLE, DONE or ERR
in_data  input  8  incoming byte
in_valid  input  1  in_data valid
in_ready  output  1  loader accepts byte this cycle
imem_we  output  1  instruction memory write strobe, one cycle per word
imem_addr  output  ADDR_W  byte address of word being written (word_index*4)
imem_wdata  output  32  assembled word
cpu_hold  output  1  1 = core held in reset
done  output  1  image loaded, level
error  output  1  length header rejected, level
words_loaded  output  16  count of words written in current load

Behaviour:
- Reset (rst=0 at clk edge): state IDLE, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=1, done=0, error=0, words_loaded=0, byte counter=0. Reset mid-load aborts immediately; partial writes are not undone.
- Handshake: byte transfers only when in_valid=1 and in_ready=1 on the same edge. in_ready is registered and is 1 only in LEN and DATA.
- IDLE:
  - start=1 -> LEN; clear byte counter, words_loaded, done, error; cpu_hold=1.
  - Without start, IDLE holds and cpu_hold=1.
- LEN: accept 4 bytes; word count N = {b3,b2,b1,b0}, first byte is the LSB. After the 4th byte:
  - N=0 -> DONE, no writes.
  - N>DEPTH_WORDS -> ERR.
  - Otherwise -> DATA.
- DATA:
  - Accept bytes into the word shift register, little-endian (byte k lands in bits [8k+7:8k]).
  - On the 4th byte -> WRITE; in_ready deasserts the following cycle.
- WRITE: exactly one cycle.
  - imem_we=1, imem_addr=words_loaded*4 (truncated to ADDR_W), imem_wdata=assembled word.
  - On that edge words_loaded increments.
  - If words_loaded+1==N -> DONE, else -> DATA.
  - Latency: imem_we is high in the cycle after the 4th byte handshake.
- DONE: done=1, cpu_hold=0, in_ready=0. start -> LEN (cpu_hold returns to 1 the next cycle).
- ERR: error=1, cpu_hold=1, in_ready=0. Only start or reset leaves ERR; start -> LEN.
- start outside IDLE/DONE/ERR is ignored.
- in_valid while in_ready=0 is ignored; the source must hold the byte.
- imem_we is never asserted outside WRITE. imem_addr/imem_wdata hold their last value otherwise.
- N is 32-bit internally; words_loaded saturation is unnecessary since N<=DEPTH_WORDS.
- Bytes arriving after DONE are not accepted.

Test Plan:
- Reset then start, stream 02 00 00 00, 13 05 A0 00, 93 05 50 00 with in_valid always 1 -> imem_we pulses twice:
  - addr 0x000, data 0x00A00513
  - addr 0x004, data 0x00500593
  - then done=1, cpu_hold=0, words_loaded=2.
- Same image with in_valid toggling 1/0 every cycle -> identical writes; no byte dropped or duplicated; in_ready=0 in each WRITE cycle.
- Header 00 00 00 00 -> DONE with no imem_we; header 01 01 00 00 (257 > 256) -> error=1, cpu_hold=1, in_ready=0; a following start recovers.
- Header for 256 words, full stream -> last write addr 0x3FC; done after exactly 256 imem_we pulses.
- rst=0 asserted after 5 data bytes -> next cycle all outputs at reset values; a fresh start reloads from addr 0.
- start pulsed mid-DATA -> ignored; the load completes normally. start in DONE -> cpu_hold=1, done=0 next cycle, header expected again.

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// The master side is the loader; the slave side is the byte source plus the memory.
interface imem_loader_if #(
    parameter int ADDR_W = 10
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        input  in_data, in_valid,
        output in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        output in_data, in_valid,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Program loader: takes a length-prefixed little-endian byte image, writes it
// word by word into instruction memory and holds the core in reset until done.
module imem_loader #(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_W      = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    imem_loader_if.master bus,
    output logic          cpu_hold,
    output logic          done,
    output logic          error,
    output logic [15:0]   words_loaded
);
    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        WRITE,
        DONE,
        ERR
    } state_t;

    state_t            state_q, state_nxt;
    logic [1:0]        bcnt_q;
    logic [23:0]       len_sr_q;
    logic [23:0]       word_sr_q;
    logic [31:0]       len_q;
    logic              in_ready_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;

    logic              xfer;
    logic              last_byte;
    logic              start_load;
    logic [31:0]       len_full;
    logic [15:0]       wl_inc;

    assign xfer       = bus.in_valid & in_ready_q;
    assign last_byte  = xfer && (bcnt_q == 2'd3);
    assign start_load = start && (state_q == IDLE || state_q == DONE || state_q == ERR);
    assign len_full   = {bus.in_data, len_sr_q};
    assign wl_inc     = words_loaded + 16'd1;

    assign bus.in_ready   = in_ready_q;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) state_nxt = LEN;
            end
            LEN: begin
                if (last_byte) begin
                    if (len_full == 32'd0)                    state_nxt = DONE;
                    else if (len_full > 32'(DEPTH_WORDS))     state_nxt = ERR;
                    else                                      state_nxt = DATA;
                end
            end
            DATA: begin
                if (last_byte) state_nxt = WRITE;
            end
            WRITE: begin
                if ({16'd0, wl_inc} == len_q) state_nxt = DONE;
                else                          state_nxt = DATA;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // All outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            in_ready_q   <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
            bcnt_q       <= '0;
        end else begin
            state_q    <= state_nxt;
            in_ready_q <= (state_nxt == LEN) || (state_nxt == DATA);
            we_q       <= (state_nxt == WRITE);
            cpu_hold   <= (state_nxt != DONE);
            done       <= (state_nxt == DONE);
            error      <= (state_nxt == ERR);

            if (start_load) begin
                bcnt_q       <= '0;
                words_loaded <= '0;
            end else begin
                if (xfer)             bcnt_q       <= bcnt_q + 2'd1;
                if (state_q == WRITE) words_loaded <= wl_inc;
            end

            if (state_q == DATA && last_byte) begin
                addr_q  <= ADDR_W'({words_loaded, 2'b00});
                wdata_q <= {bus.in_data, word_sr_q};
            end
        end
    end

    // Shift registers fill from the top so byte k ends up in bits [8k+7:8k].
    always_ff @(posedge clk) begin
        if (xfer && state_q == LEN) begin
            len_sr_q <= {bus.in_data, len_sr_q[23:8]};
            if (bcnt_q == 2'd3) len_q <= len_full;
        end
        if (xfer && state_q == DATA) begin
            word_sr_q <= {bus.in_data, word_sr_q[23:8]};
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: directed images, expected writes queued
// by the stimulus and checked by an independent write monitor.
module tb_imem_loader;
    localparam int ADDR_W      = 10;
    localparam int DEPTH_WORDS = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        cpu_hold, done, error;
    logic [15:0] words_loaded;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus();

    imem_loader #(.DEPTH_WORDS(DEPTH_WORDS), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .start(start), .bus(bus),
        .cpu_hold(cpu_hold), .done(done), .error(error), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [31:0]       d;
    } exp_t;

    exp_t              sb[$];
    int                tests = 0;
    int                fails = 0;
    int                we_cnt = 0;
    logic [ADDR_W-1:0] last_addr = '0;

    localparam logic [7:0] IMG2 [12] = '{8'h02, 8'h00, 8'h00, 8'h00,
                                          8'h13, 8'h05, 8'hA0, 8'h00,
                                          8'h93, 8'h05, 8'h50, 8'h00};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Write monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst && bus.imem_we === 1'b1) begin
            exp_t e;
            we_cnt++;
            last_addr = bus.imem_addr;
            chk("write_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL write_unexpected: got addr %h data %h expected no write",
                         bus.imem_addr, bus.imem_wdata);
            end else begin
                e = sb.pop_front();
                chk("write_addr", {22'd0, bus.imem_addr}, {22'd0, e.a});
                chk("write_data", bus.imem_wdata, e.d);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int   n = 0;
        logic hs = 1'b0;
        while (!hs && n < 50) begin
            @(negedge clk);
            bus.in_data  = b;
            bus.in_valid = 1'b1;
            hs = bus.in_ready;
            @(posedge clk);
            n++;
        end
        if (!hs) begin
            tests++;
            fails++;
            $display("FAIL send_byte_timeout: got in_ready=0 for 50 cycles expected 1 (byte %h)", b);
        end
        if (gap > 0) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            @(posedge clk);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.in_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input int lim);
        int n = 0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        while (!(done || error) && n < lim) begin
            @(negedge clk);
            n++;
        end
        if (!(done || error)) begin
            tests++;
            fails++;
            $display("FAIL wait_end_timeout: got done=%b error=%b expected one set", done, error);
        end
    endtask

    task automatic load_img2(input int gap);
        sb.push_back('{a: 10'h000, d: 32'h00A00513});
        sb.push_back('{a: 10'h004, d: 32'h00500593});
        for (int k = 0; k < 12; k++) send_byte(IMG2[k], gap);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"},  {31'd0, bus.in_ready}, 32'd0);
        chk({tag, "_imem_we"},   {31'd0, bus.imem_we},  32'd0);
        chk({tag, "_imem_addr"}, {22'd0, bus.imem_addr}, 32'd0);
        chk({tag, "_imem_wdata"}, bus.imem_wdata, 32'd0);
        chk({tag, "_cpu_hold"},  {31'd0, cpu_hold}, 32'd1);
        chk({tag, "_done"},      {31'd0, done}, 32'd0);
        chk({tag, "_error"},     {31'd0, error}, 32'd0);
        chk({tag, "_words"},     {16'd0, words_loaded}, 32'd0);
    endtask

    task automatic check_done(input string tag, input int words, input int writes);
        chk({tag, "_done"},     {31'd0, done}, 32'd1);
        chk({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd0);
        chk({tag, "_error"},    {31'd0, error}, 32'd0);
        chk({tag, "_words"},    {16'd0, words_loaded}, words);
        chk({tag, "_writes"},   we_cnt, writes);
        chk({tag, "_sb_empty"}, sb.size(), 32'd0);
    endtask

    initial begin
        int base;
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("idle");

        // Two-word image, valid always high
        base = we_cnt;
        pulse_start();
        load_img2(0);
        wait_end(20);
        check_done("img2", 2, base + 2);

        // Same image, valid toggling every cycle
        base = we_cnt;
        pulse_start();
        load_img2(1);
        wait_end(20);
        check_done("img2_gap", 2, base + 2);

        // Zero-length header
        base = we_cnt;
        pulse_start();
        send_word(32'h0000_0000, 0);
        wait_end(20);
        check_done("zero_len", 0, base);

        // 257 words is over capacity
        pulse_start();
        send_word(32'h0000_0101, 0);
        wait_end(20);
        repeat (2) @(negedge clk);
        chk("err_error",    {31'd0, error}, 32'd1);
        chk("err_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        chk("err_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("err_done",     {31'd0, done}, 32'd0);
        base = we_cnt;
        pulse_start();
        chk("err_recover_error", {31'd0, error}, 32'd0);
        load_img2(0);
        wait_end(20);
        check_done("err_recover", 2, base + 2);

        // Full-capacity image
        base = we_cnt;
        pulse_start();
        send_word(32'h0000_0100, 0);
        for (int i = 0; i < 256; i++) begin
            logic [7:0]  ib;
            logic [31:0] w;
            ib = i[7:0];
            w  = {ib, 8'hC3, ~ib, ib ^ 8'h5A};
            sb.push_back('{a: ADDR_W'(i * 4), d: w});
            send_word(w, 0);
        end
        wait_end(20);
        check_done("full", 256, base + 256);
        chk("full_last_addr", {22'd0, last_addr}, 32'h3FC);

        // Reset after five data bytes
        pulse_start();
        sb.push_back('{a: 10'h000, d: 32'h00A00513});
        for (int k = 0; k < 9; k++) send_byte(IMG2[k], 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrst");
        chk("midrst_sb_empty", sb.size(), 32'd0);
        rst = 1'b1;
        base = we_cnt;
        pulse_start();
        load_img2(0);
        wait_end(20);
        check_done("midrst_reload", 2, base + 2);

        // start during DATA is ignored
        base = we_cnt;
        pulse_start();
        sb.push_back('{a: 10'h000, d: 32'h00A00513});
        sb.push_back('{a: 10'h004, d: 32'h00500593});
        for (int k = 0; k < 6; k++) send_byte(IMG2[k], 0);
        pulse_start();
        for (int k = 6; k < 12; k++) send_byte(IMG2[k], 0);
        wait_end(20);
        check_done("start_mid", 2, base + 2);

        // start in DONE expects a fresh header
        pulse_start();
        chk("restart_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        chk("restart_done",     {31'd0, done}, 32'd0);
        chk("restart_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("restart_words",    {16'd0, words_loaded}, 32'd0);
        base = we_cnt;
        send_word(32'h0000_0000, 0);
        wait_end(20);
        check_done("restart_zero", 0, base);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
